// File: rtl/branch_resolve_queue.sv
//==============================================================================
// Module   : branch_resolve_queue
// Purpose  : In-order queue of predicted conditional branches awaiting EX
//            resolution; emits predictor feedback and mispredict redirects.
//            Optional counters enabled by defining BRQ_STATS_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module branch_resolve_queue #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enq_valid,
  input  logic [ADDR_WIDTH-1:0] enq_pc,
  input  logic                  enq_prediction,
  input  logic [ADDR_WIDTH-1:0] enq_recovery_target,
  output logic                  enq_ready,
  input  logic                  res_valid,
  input  logic                  res_outcome,
  output logic                  fb_valid,
  output logic [ADDR_WIDTH-1:0] fb_pc,
  output logic                  fb_prediction,
  output logic                  fb_outcome,
  output logic                  redirect_valid,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [CNT_W-1:0]      count,
  output logic                  err_underflow,
  output logic [15:0]           stat_resolved,
  output logic [15:0]           stat_mispredict
);

  localparam int c_PTR_W = $clog2(DEPTH);

  logic [ADDR_WIDTH-1:0] r_pc_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_rt_mem [DEPTH];
  logic [DEPTH-1:0]      r_pred_mem;

  logic [c_PTR_W-1:0]    r_head;
  logic [c_PTR_W-1:0]    r_tail;
  logic [CNT_W-1:0]      r_count;

  logic                  r_fb_valid;
  logic [ADDR_WIDTH-1:0] r_fb_pc;
  logic                  r_fb_prediction;
  logic                  r_fb_outcome;
  logic                  r_redirect_valid;
  logic [ADDR_WIDTH-1:0] r_redirect_pc;
  logic                  r_err_underflow;

  logic                  w_enq_fire;
  logic                  w_res_fire;
  logic                  w_mispredict;

  // No pop bypass: readiness depends only on the registered occupancy.
  assign enq_ready    = (r_count < CNT_W'(DEPTH));
  assign w_enq_fire   = enq_valid && enq_ready;
  assign w_res_fire   = res_valid && (r_count != '0);
  assign w_mispredict = w_res_fire && (res_outcome != r_pred_mem[r_head]);

  // Storage needs no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (!rst && w_enq_fire && !w_mispredict) begin
      r_pc_mem[r_tail]   <= enq_pc;
      r_rt_mem[r_tail]   <= enq_recovery_target;
      r_pred_mem[r_tail] <= enq_prediction;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head           <= '0;
      r_tail           <= '0;
      r_count          <= '0;
      r_fb_valid       <= 1'b0;
      r_fb_pc          <= '0;
      r_fb_prediction  <= 1'b0;
      r_fb_outcome     <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_err_underflow  <= 1'b0;
    end else begin
      r_fb_valid       <= w_res_fire;
      r_redirect_valid <= w_mispredict;

      if (w_res_fire) begin
        r_fb_pc         <= r_pc_mem[r_head];
        r_fb_prediction <= r_pred_mem[r_head];
        r_fb_outcome    <= res_outcome;
      end

      if (res_valid && (r_count == '0)) begin
        r_err_underflow <= 1'b1;
      end

      // A mispredict flushes everything younger, including a same-cycle enq.
      if (w_mispredict) begin
        r_redirect_pc <= r_rt_mem[r_head];
        r_head        <= '0;
        r_tail        <= '0;
        r_count       <= '0;
      end else begin
        if (w_enq_fire) begin
          r_tail <= r_tail + c_PTR_W'(1);
        end
        if (w_res_fire) begin
          r_head <= r_head + c_PTR_W'(1);
        end
        if (w_enq_fire && !w_res_fire) begin
          r_count <= r_count + CNT_W'(1);
        end else if (!w_enq_fire && w_res_fire) begin
          r_count <= r_count - CNT_W'(1);
        end
      end
    end
  end

  assign fb_valid       = r_fb_valid;
  assign fb_pc          = r_fb_pc;
  assign fb_prediction  = r_fb_prediction;
  assign fb_outcome     = r_fb_outcome;
  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;
  assign count          = r_count;
  assign err_underflow  = r_err_underflow;

`ifdef BRQ_STATS_EN
  logic [15:0] r_stat_resolved;
  logic [15:0] r_stat_mispredict;

  // Saturating counters, updated on the same edge that raises fb_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_resolved   <= '0;
      r_stat_mispredict <= '0;
    end else begin
      if (w_res_fire && (r_stat_resolved != 16'hFFFF)) begin
        r_stat_resolved <= r_stat_resolved + 16'd1;
      end
      if (w_mispredict && (r_stat_mispredict != 16'hFFFF)) begin
        r_stat_mispredict <= r_stat_mispredict + 16'd1;
      end
    end
  end

  assign stat_resolved   = r_stat_resolved;
  assign stat_mispredict = r_stat_mispredict;
`else
  assign stat_resolved   = 16'd0;
  assign stat_mispredict = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve_queue.sv
//==============================================================================
// Module   : tb_branch_resolve_queue
// Purpose  : Directed, table-driven checks for branch_resolve_queue (DEPTH=4).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_branch_resolve_queue;

  logic        clk;
  logic        rst;
  logic        enq_valid;
  logic [31:0] enq_pc;
  logic        enq_prediction;
  logic [31:0] enq_recovery_target;
  logic        enq_ready;
  logic        res_valid;
  logic        res_outcome;
  logic        fb_valid;
  logic [31:0] fb_pc;
  logic        fb_prediction;
  logic        fb_outcome;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [2:0]  count;
  logic        err_underflow;
  logic [15:0] stat_resolved;
  logic [15:0] stat_mispredict;

  int n_pass;
  int n_total;

  branch_resolve_queue #(
    .DEPTH(4),
    .ADDR_WIDTH(32)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .enq_valid           (enq_valid),
    .enq_pc              (enq_pc),
    .enq_prediction      (enq_prediction),
    .enq_recovery_target (enq_recovery_target),
    .enq_ready           (enq_ready),
    .res_valid           (res_valid),
    .res_outcome         (res_outcome),
    .fb_valid            (fb_valid),
    .fb_pc               (fb_pc),
    .fb_prediction       (fb_prediction),
    .fb_outcome          (fb_outcome),
    .redirect_valid      (redirect_valid),
    .redirect_pc         (redirect_pc),
    .count               (count),
    .err_underflow       (err_underflow),
    .stat_resolved       (stat_resolved),
    .stat_mispredict     (stat_mispredict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ev;
    logic [31:0] epc;
    logic        ep;
    logic [31:0] ert;
    logic        rv;
    logic        ro;
    logic        xfb;
    logic [31:0] xpc;
    logic        xpred;
    logic        xout;
    logic        xredir;
    logic [31:0] xrpc;
    logic [2:0]  xcnt;
    logic        xrdy;
    logic        xerr;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic r, logic ev, logic [31:0] epc, logic ep,
                              logic [31:0] ert, logic rv, logic ro, logic xfb,
                              logic [31:0] xpc, logic xpred, logic xout,
                              logic xredir, logic [31:0] xrpc, logic [2:0] xcnt,
                              logic xrdy, logic xerr);
    vec_t v;
    v.rst = r;     v.ev = ev;       v.epc = epc;   v.ep = ep;   v.ert = ert;
    v.rv = rv;     v.ro = ro;       v.xfb = xfb;   v.xpc = xpc; v.xpred = xpred;
    v.xout = xout; v.xredir = xredir; v.xrpc = xrpc; v.xcnt = xcnt;
    v.xrdy = xrdy; v.xerr = xerr;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(vec_t v);
    rst                 = v.rst;
    enq_valid           = v.ev;
    enq_pc              = v.epc;
    enq_prediction      = v.ep;
    enq_recovery_target = v.ert;
    res_valid           = v.rv;
    res_outcome         = v.ro;
  endtask

  // Drive one cycle of inputs, then compare the state after the edge.
  task automatic apply(vec_t v, int idx);
    string tag;
    drive(v);
    @(posedge clk);
    #1;
    tag = $sformatf("v%0d", idx);
    chk({tag, ".fb_valid"}, 32'(fb_valid), 32'(v.xfb));
    chk({tag, ".redirect_valid"}, 32'(redirect_valid), 32'(v.xredir));
    chk({tag, ".count"}, 32'(count), 32'(v.xcnt));
    chk({tag, ".enq_ready"}, 32'(enq_ready), 32'(v.xrdy));
    chk({tag, ".err_underflow"}, 32'(err_underflow), 32'(v.xerr));
    if (v.xfb) begin
      chk({tag, ".fb_pc"}, fb_pc, v.xpc);
      chk({tag, ".fb_prediction"}, 32'(fb_prediction), 32'(v.xpred));
      chk({tag, ".fb_outcome"}, 32'(fb_outcome), 32'(v.xout));
    end
    if (v.xredir) chk({tag, ".redirect_pc"}, redirect_pc, v.xrpc);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));

    //          rst ev epc    ep ert    rv ro fb pc     pr ou rd rpc    cnt rdy err
    // reset, single correctly predicted branch
    vq.push_back(mk(1, 0, 0,      0, 0,      0, 0, 0, 0,      0, 0, 0, 0,      0, 1, 0));
    vq.push_back(mk(0, 1, 'h100,  1, 'h108,  0, 0, 0, 0,      0, 0, 0, 0,      1, 1, 0));
    vq.push_back(mk(0, 0, 0,      0, 0,      1, 1, 1, 'h100,  1, 1, 0, 0,      0, 1, 0));
    // three not-taken branches, oldest mispredicts, then underflow
    vq.push_back(mk(0, 1, 'h200,  0, 'h300,  0, 0, 0, 0,      0, 0, 0, 0,      1, 1, 0));
    vq.push_back(mk(0, 1, 'h210,  0, 'h310,  0, 0, 0, 0,      0, 0, 0, 0,      2, 1, 0));
    vq.push_back(mk(0, 1, 'h220,  0, 'h320,  0, 0, 0, 0,      0, 0, 0, 0,      3, 1, 0));
    vq.push_back(mk(0, 0, 0,      0, 0,      1, 1, 1, 'h200,  0, 1, 1, 'h300,  0, 1, 0));
    vq.push_back(mk(0, 0, 0,      0, 0,      1, 0, 0, 0,      0, 0, 0, 0,      0, 1, 1));
    vq.push_back(mk(1, 0, 0,      0, 0,      0, 0, 0, 0,      0, 0, 0, 0,      0, 1, 0));
    // fill to DEPTH; a full queue refuses enq even with a pop in the same cycle
    vq.push_back(mk(0, 1, 'hA00,  1, 'hA08,  0, 0, 0, 0,      0, 0, 0, 0,      1, 1, 0));
    vq.push_back(mk(0, 1, 'hA10,  1, 'hA18,  0, 0, 0, 0,      0, 0, 0, 0,      2, 1, 0));
    vq.push_back(mk(0, 1, 'hA20,  1, 'hA28,  0, 0, 0, 0,      0, 0, 0, 0,      3, 1, 0));
    vq.push_back(mk(0, 1, 'hA30,  1, 'hA38,  0, 0, 0, 0,      0, 0, 0, 0,      4, 0, 0));
    vq.push_back(mk(0, 1, 'hB00,  1, 'hB08,  1, 1, 1, 'hA00,  1, 1, 0, 0,      3, 1, 0));
    vq.push_back(mk(0, 0, 0,      0, 0,      1, 1, 1, 'hA10,  1, 1, 0, 0,      2, 1, 0));
    vq.push_back(mk(0, 0, 0,      0, 0,      1, 1, 1, 'hA20,  1, 1, 0, 0,      1, 1, 0));
    vq.push_back(mk(0, 0, 0,      0, 0,      1, 1, 1, 'hA30,  1, 1, 0, 0,      0, 1, 0));
    // streaming push/pop across the pointer wrap
    vq.push_back(mk(0, 1, 'hC00,  0, 'hC08,  0, 0, 0, 0,      0, 0, 0, 0,      1, 1, 0));
    for (int k = 0; k < 10; k++)
      vq.push_back(mk(0, 1, 32'h0C10 + 32'(16 * k), 0, 32'h0F00, 1, 0,
                      1, 32'h0C00 + 32'(16 * k), 0, 0, 0, 0, 1, 1, 0));
    vq.push_back(mk(0, 0, 0,      0, 0,      1, 0, 1, 'hCA0,  0, 0, 0, 0,      0, 1, 0));
    // mispredict discards a same-cycle enq
    vq.push_back(mk(0, 1, 'hD00,  1, 'hD80,  0, 0, 0, 0,      0, 0, 0, 0,      1, 1, 0));
    vq.push_back(mk(0, 1, 'h400,  0, 'h480,  1, 0, 1, 'hD00,  1, 0, 1, 'hD80,  0, 1, 0));
    vq.push_back(mk(0, 0, 0,      0, 0,      1, 1, 0, 0,      0, 0, 0, 0,      0, 1, 1));
    // underflowing resolve still lets a same-cycle enq in
    vq.push_back(mk(0, 1, 'hE00,  1, 'hE08,  1, 1, 0, 0,      0, 0, 0, 0,      1, 1, 1));
    vq.push_back(mk(0, 0, 0,      0, 0,      1, 1, 1, 'hE00,  1, 1, 0, 0,      0, 1, 1));

    foreach (vq[i]) apply(vq[i], i);

    // Stats: 5 resolves (last 2 mispredicted) after a clean reset.
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 100);
    chk("stat_resolved_reset", 32'(stat_resolved), 32'd0);
    for (int k = 0; k < 5; k++) begin
      apply(mk(0, 1, 32'h0500 + 32'(16 * k), 1, 32'h0600 + 32'(16 * k), 0, 0,
               0, 0, 0, 0, 0, 0, 1, 1, 0), 110 + 2 * k);
      apply(mk(0, 0, 0, 0, 0, 1, (k < 3) ? 1'b1 : 1'b0,
               1, 32'h0500 + 32'(16 * k), 1, (k < 3) ? 1'b1 : 1'b0,
               (k < 3) ? 1'b0 : 1'b1, 32'h0600 + 32'(16 * k), 0, 1, 0), 111 + 2 * k);
    end
`ifdef BRQ_STATS_EN
    chk("stat_resolved", 32'(stat_resolved), 32'd5);
    chk("stat_mispredict", 32'(stat_mispredict), 32'd2);
`else
    chk("stat_resolved", 32'(stat_resolved), 32'd0);
    chk("stat_mispredict", 32'(stat_mispredict), 32'd0);
`endif

    // Mid-stream reset with everything else active clears all outputs.
    apply(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1), 130);
    apply(mk(0, 1, 'h700, 1, 'h708, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1), 131);
    apply(mk(0, 1, 'h710, 1, 'h718, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 1), 132);
    apply(mk(1, 1, 'h720, 1, 'h728, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 133);
    chk("rst.fb_pc", fb_pc, 32'd0);
    chk("rst.fb_prediction", 32'(fb_prediction), 32'd0);
    chk("rst.fb_outcome", 32'(fb_outcome), 32'd0);
    chk("rst.redirect_pc", redirect_pc, 32'd0);
    chk("rst.stat_resolved", 32'(stat_resolved), 32'd0);
    chk("rst.stat_mispredict", 32'(stat_mispredict), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- Tracks in-flight conditional branches between decode (prediction made) and EX (outcome known), in program order.
- On each EX resolution, pops the oldest entry and emits registered predictor feedback (pc, prediction, outcome).
- On a misprediction, emits a one-cycle redirect to the stored recovery target and flushes all younger entries.
- Sits beside branch_controller: decode side enqueues, EX side resolves, feedback output drives the predictor training port.

Parameters:
- DEPTH, 4, queue entries; power of two, >= 2
- ADDR_WIDTH, 32, PC / target width
- CNT_W, $clog2(DEPTH+1), width of occupancy count

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- enq_valid  in  1  decoded conditional branch with prediction, this cycle
- enq_pc  in  ADDR_WIDTH  branch PC
- enq_prediction  in  1  1 = TAKEN, 0 = NOT_TAKEN
- enq_recovery_target  in  ADDR_WIDTH  PC to fetch if the prediction is wrong
- enq_ready  out  1  queue can accept (count < DEPTH)
- res_valid  in  1  EX resolved the oldest outstanding branch
- res_outcome  in  1  actual direction, 1 = TAKEN
- fb_valid  out  1  registered feedback strobe
- fb_pc  out  ADDR_WIDTH  PC of resolved branch
- fb_prediction  out  1  stored prediction
- fb_outcome  out  1  actual outcome
- redirect_valid  out  1  misprediction strobe
- redirect_pc  out  ADDR_WIDTH  recovery target of the mispredicted branch
- count  out  CNT_W  current occupancy
- err_underflow  out  1  sticky: res_valid seen while queue empty
- stat_resolved  out  16  resolved-branch counter (optional feature)
- stat_mispredict  out  16  misprediction counter (optional feature)

Behaviour:
- Storage: circular buffer of {pc, prediction, recovery_target}, with head/tail pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus a count register.
- Reset (rst=1 at a clk edge): head = tail = count = 0; fb_*, redirect_*, err_underflow, and stats all 0. Reset wins over every other input.
- Enqueue: accepted when enq_valid && enq_ready. Entry is written at tail; tail++.
- enq_ready is combinational from the registered count only. There is no same-cycle pop bypass, so a full queue refuses enq even when res_valid is high.
- Resolve: when res_valid && count != 0, the head entry is read.
  - Next cycle: fb_valid=1, fb_pc = head.pc, fb_prediction = head.prediction, fb_outcome = res_outcome.
  - head++ and count--.
  - Latency is exactly 1 cycle. fb_valid is a single-cycle pulse per resolve and is 0 otherwise; fb data holds its last value when fb_valid=0.
- Mispredict (res_outcome != head.prediction):
  - Next cycle: redirect_valid=1 and redirect_pc = head.recovery_target, in the same cycle as fb_valid.
  - Queue flush: head = tail = 0, count = 0.
  - Any enq accepted in the same cycle is discarded, because it is on the wrong path.
- Correct prediction: redirect_valid=0; redirect_pc holds.
- Simultaneous enq + correct resolve: both take effect; count is unchanged.
- res_valid with count==0: ignored (no fb, no pop), err_underflow set to 1 until reset. An enq in the same cycle is still accepted.
- count never exceeds DEPTH, and never goes below 0.

Optional Feature:
- Macro: BRQ_STATS_EN.
- Defined:
  - stat_resolved increments on every accepted resolve.
  - stat_mispredict increments on every mispredict.
  - Both are 16-bit, saturate at 16'hFFFF, update in the same cycle as fb_valid, and clear on reset.
- Undefined: both ports are still present and tied to 0; no counter flops are synthesized.

Test Plan:
- Reset, then enq pc=0x100 pred=1 rt=0x108; next cycle res_valid outcome=1 -> one cycle later fb_valid=1, fb_pc=0x100, fb_prediction=1, fb_outcome=1, redirect_valid=0, count=0.
- Enq 3 branches (0x200, 0x210, 0x220, all pred=0, rt=0x300/0x310/0x320); resolve oldest with outcome=1 -> redirect_valid=1, redirect_pc=0x300, fb_pc=0x200, count=0. A following res_valid -> err_underflow=1, no fb.
- Fill DEPTH=4 entries -> enq_ready=0. Enq+res in the same cycle -> enq dropped, count=3. Next cycle enq_ready=1.
- Push/pop 10 correctly predicted branches with enq and res in the same cycle, forcing pointer wrap -> fb_pc sequence is in exact enqueue order, count is constant at 1.
- Mispredict resolve while enq_valid=1 (pc=0x400) -> 0x400 is not present afterwards: count=0, and the next res_valid flags err_underflow.
- With BRQ_STATS_EN: 5 resolves, 2 mispredicts -> stat_resolved=5, stat_mispredict=2. Assert rst mid-stream -> all outputs 0 the next cycle. Without the macro -> both stats stay 0.
